// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Runs a programmable serial-pattern detector over one captured data word.
//   A Start in IDLE captures Data/Pat/PatLen and scans the word MSB-first,
//   one bit per clock, through a shift-history detector. Overlapping
//   occurrences raise a one-cycle Match pulse and bump a saturating Count.
//   An out-of-range PatLen skips the scan, reports Err and still pulses Done.
//
// Ports
//   Clk     system clock, rising edge
//   Clr     asynchronous reset, active low
//   Start   command strobe, only honoured in IDLE
//   Data    word to scan (DW bits)
//   Pat     pattern; bit PatLen-1 is the oldest bit of a match
//   PatLen  pattern length, legal 1..PMAX
//   Busy    high while scanning
//   Done    one-cycle completion pulse
//   Match   registered pulse per detected occurrence
//   Count   saturating match count of the current/last scan
//   Err     last accepted command had an illegal PatLen
//
// state | meaning
// IDLE  | waiting for Start; Count and Err hold the last result
// SCAN  | consuming one data bit per clock, MSB first
// DONE  | single completion cycle, then back to IDLE

module pattern_scan_ctrl #(
    parameter int DW   = 16,
    parameter int PMAX = 8,
    parameter int CW   = 4
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            Start,
    input  logic [DW-1:0]   Data,
    input  logic [PMAX-1:0] Pat,
    input  logic [3:0]      PatLen,
    output logic            Busy,
    output logic            Done,
    output logic            Match,
    output logic [CW-1:0]   Count,
    output logic            Err
);

    localparam int IW = (DW > 1) ? $clog2(DW) : 1;
    localparam int SW = $clog2(PMAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   data_reg;
    logic [PMAX-1:0] pat_reg;
    logic [3:0]      len_reg;
    // Only PMAX-1 past bits need storing; the newest bit joins in hist_next.
    logic [PMAX-2:0] hist;
    logic [SW-1:0]   seen;
    logic [IW-1:0]   idx;

    logic [PMAX-1:0] hist_next;
    logic [PMAX-1:0] len_mask;
    logic [SW-1:0]   seen_next;
    logic            hit;
    logic            len_bad;

    always_comb begin
        hist_next = {hist, data_reg[idx]};
        seen_next = (int'(seen) < PMAX) ? seen + SW'(1) : seen;
        for (int i = 0; i < PMAX; i++) begin
            len_mask[i] = (i < int'(len_reg));
        end
        // seen_next guards against matching on history that predates this scan.
        hit = (int'(seen_next) >= int'(len_reg)) &&
              ((hist_next & len_mask) == (pat_reg & len_mask));
    end

    assign len_bad = (PatLen == 4'd0) || (int'(PatLen) > PMAX);

    assign Busy = (state == SCAN);
    assign Done = (state == DONE);

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state    <= IDLE;
            data_reg <= '0;
            pat_reg  <= '0;
            len_reg  <= '0;
            hist     <= '0;
            seen     <= '0;
            idx      <= '0;
            Match    <= 1'b0;
            Count    <= '0;
            Err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        data_reg <= Data;
                        pat_reg  <= Pat;
                        len_reg  <= PatLen;
                        Count    <= '0;
                        Match    <= 1'b0;
                        hist     <= '0;
                        seen     <= '0;
                        idx      <= IW'(DW - 1);
                        if (len_bad) begin
                            Err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            Err   <= 1'b0;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    hist  <= hist_next[PMAX-2:0];
                    seen  <= seen_next;
                    Match <= hit;
                    if (hit && (Count != '1)) begin
                        Count <= Count + CW'(1);
                    end
                    if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Match <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl: directed commands, a window-based
// reference model compared every cycle, and literal expectations per scenario.

module tb_pattern_scan_ctrl;

    localparam int DW   = 16;
    localparam int PMAX = 8;
    localparam int CW   = 4;

    logic            Clk    = 1'b0;
    logic            Clr    = 1'b0;
    logic            Start  = 1'b0;
    logic [DW-1:0]   Data   = '0;
    logic [PMAX-1:0] Pat    = '0;
    logic [3:0]      PatLen = '0;
    logic            Busy;
    logic            Done;
    logic            Match;
    logic [CW-1:0]   Count;
    logic            Err;

    pattern_scan_ctrl #(.DW(DW), .PMAX(PMAX), .CW(CW)) dut (
        .Clk    (Clk),
        .Clr    (Clr),
        .Start  (Start),
        .Data   (Data),
        .Pat    (Pat),
        .PatLen (PatLen),
        .Busy   (Busy),
        .Done   (Done),
        .Match  (Match),
        .Count  (Count),
        .Err    (Err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference model: ph = 0 idle, 1..DW = next bit number to consume,
    // DW+1 = completion cycle. A match at bit k means the last m_len consumed
    // bits of the word equal the low m_len bits of the pattern.
    int              ph = 0;
    logic [DW-1:0]   m_data = '0;
    logic [PMAX-1:0] m_pat = '0;
    int              m_len = 0;
    int              e_cnt = 0;
    bit              e_match = 1'b0;
    bit              e_err = 1'b0;

    function automatic bit model_hit(input int k);
        logic [DW-1:0] win;
        if (k < m_len) return 1'b0;
        win = m_data >> (DW - k);
        for (int i = 0; i < m_len; i++) begin
            if (win[i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            ph = 0; e_cnt = 0; e_match = 1'b0; e_err = 1'b0;
        end else if (ph == 0) begin
            if (Start) begin
                m_data = Data; m_pat = Pat; m_len = int'(PatLen);
                e_cnt = 0; e_match = 1'b0;
                if (m_len < 1 || m_len > PMAX) begin
                    e_err = 1'b1; ph = DW + 1;
                end else begin
                    e_err = 1'b0; ph = 1;
                end
            end
        end else if (ph <= DW) begin
            e_match = model_hit(ph);
            if (e_match && e_cnt < (1 << CW) - 1) e_cnt++;
            ph++;
        end else begin
            ph = 0; e_match = 1'b0;
        end
    end

    always @(negedge Clk) begin
        check("busy",  int'(Busy),  int'(ph >= 1 && ph <= DW));
        check("done",  int'(Done),  int'(ph == DW + 1));
        check("match", int'(Match), int'(e_match));
        check("count", int'(Count), e_cnt);
        check("err",   int'(Err),   int'(e_err));
    end

    // Issues one command and observes the negedge after E0..E_DW+1.
    // mv[k] = Match seen after edge Ek.
    task automatic run_cmd(input logic [DW-1:0] d, input logic [PMAX-1:0] p,
                           input logic [3:0] l, output logic [DW+1:0] mv,
                           output int cnt, output int err, output int done_at,
                           output int busy_cycles);
        mv = '0; cnt = -1; err = -1; done_at = -1; busy_cycles = 0;
        @(negedge Clk);
        Data = d; Pat = p; PatLen = l; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int k = 0; k <= DW + 1; k++) begin
            if (k > 0) @(negedge Clk);
            if (Match) mv[k] = 1'b1;
            if (Busy) busy_cycles++;
            if (Done && done_at < 0) begin
                done_at = k; cnt = int'(Count); err = int'(Err);
            end
        end
    endtask

    initial begin
        logic [DW+1:0] mv;
        int cnt, err, dn, bc;
        int rise[2];
        int n_rise, nd, cyc;
        int done_cnt[2];
        logic prev_busy;

        repeat (2) @(negedge Clk);
        check("rst_busy",  int'(Busy),  0);
        check("rst_done",  int'(Done),  0);
        check("rst_match", int'(Match), 0);
        check("rst_count", int'(Count), 0);
        check("rst_err",   int'(Err),   0);
        Clr = 1'b1;

        // Overlapping 101 in A5A5: hits at E3, E8, E11, E16
        run_cmd(16'hA5A5, 8'b0000_0101, 4'd3, mv, cnt, err, dn, bc);
        check("basic_pos",  int'(mv), (1 << 3) | (1 << 8) | (1 << 11) | (1 << 16));
        check("basic_busy", bc, 16);
        check("basic_done", dn, 16);
        check("basic_cnt",  cnt, 4);
        check("basic_err",  err, 0);

        // Saturation at 15
        run_cmd(16'hFFFF, 8'h01, 4'd1, mv, cnt, err, dn, bc);
        check("sat_pos", int'(mv), 32'h1FFFE);
        check("sat_cnt", cnt, 15);

        // Illegal lengths
        run_cmd(16'hA5A5, 8'h05, 4'd0, mv, cnt, err, dn, bc);
        check("bad0_busy", bc, 0);
        check("bad0_done", dn, 0);
        check("bad0_err",  err, 1);
        check("bad0_cnt",  cnt, 0);
        check("bad0_pos",  int'(mv), 0);
        run_cmd(16'hA5A5, 8'h05, 4'd9, mv, cnt, err, dn, bc);
        check("bad9_busy", bc, 0);
        check("bad9_done", dn, 0);
        check("bad9_err",  err, 1);
        check("bad9_pos",  int'(mv), 0);

        // Full-length pattern, also clears Err
        run_cmd(16'h00A5, 8'hA5, 4'd8, mv, cnt, err, dn, bc);
        check("full_lo_pos", int'(mv), 1 << 16);
        check("full_lo_cnt", cnt, 1);
        check("full_lo_err", err, 0);
        run_cmd(16'hA500, 8'hA5, 4'd8, mv, cnt, err, dn, bc);
        check("full_hi_pos", int'(mv), 1 << 8);
        check("full_hi_cnt", cnt, 1);

        // Asynchronous reset mid-scan (Count is 1 after E3 at that point)
        @(negedge Clk);
        Data = 16'hA5A5; Pat = 8'h05; PatLen = 4'd3; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        #2 Clr = 1'b0;
        #1;
        check("midrst_busy",  int'(Busy),  0);
        check("midrst_match", int'(Match), 0);
        check("midrst_count", int'(Count), 0);
        repeat (3) begin
            @(negedge Clk);
            check("midrst_nodone", int'(Done), 0);
        end
        Clr = 1'b1;
        run_cmd(16'hA5A5, 8'b0000_0101, 4'd3, mv, cnt, err, dn, bc);
        check("after_rst_pos", int'(mv), (1 << 3) | (1 << 8) | (1 << 11) | (1 << 16));
        check("after_rst_cnt", cnt, 4);

        // Start held high; Data changes during the first scan
        n_rise = 0; nd = 0; rise[0] = -1; rise[1] = -1;
        done_cnt[0] = -1; done_cnt[1] = -1;
        prev_busy = 1'b0;
        @(negedge Clk);
        Data = 16'hA5A5; Pat = 8'h05; PatLen = 4'd3; Start = 1'b1;
        for (cyc = 1; cyc <= 35; cyc++) begin
            @(negedge Clk);
            if (cyc == 5) Data = 16'h0005;
            if (Busy && !prev_busy && n_rise < 2) begin
                rise[n_rise] = cyc; n_rise++;
            end
            prev_busy = Busy;
            if (Done && nd < 2) begin
                done_cnt[nd] = int'(Count); nd++;
            end
        end
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        check("hold_rises",  n_rise, 2);
        check("hold_period", rise[1] - rise[0], DW + 2);
        check("hold_dones",  nd, 2);
        check("hold_cnt1",   done_cnt[0], 4);
        check("hold_cnt2",   done_cnt[1], 1);
        check("hold_idle",   int'(Busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Controller that runs a programmable serial-pattern detector over a parallel data word.
- On a command it captures the word, the pattern and the pattern length, then feeds the word MSB-first through a shift-history detector, one bit per clock.
- It reports each overlapping match as a registered (Moore) pulse, keeps a saturating match count, and signals completion.
- It sits between the bus-side command logic and the sequence-detector datapath and owns all sequencing of that datapath.

Parameters:
- DW, 16, data word width in bits (bits scanned per command).
- PMAX, 8, maximum pattern length in bits.
- CW, 4, match counter width; the counter saturates at 2^CW-1.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Clr  in  1  asynchronous active-low reset (0 = reset asserted).
- Start  in  1  command strobe; sampled only in IDLE.
- Data  in  DW  word to scan; captured on an accepted Start.
- Pat  in  PMAX  pattern; low PatLen bits are used, bit PatLen-1 is matched first in time.
- PatLen  in  4  pattern length; legal range 1..PMAX.
- Busy  out  1  high while in SCAN.
- Done  out  1  high for exactly one cycle, in the DONE state.
- Match  out  1  registered pulse, one cycle per detected occurrence.
- Count  out  CW  matches in the current or last scan; saturating.
- Err  out  1  high when the last command had an illegal PatLen; held until the next accepted Start.

Behaviour:
- Reset (Clr=0, async): state=IDLE; Busy=0, Done=0, Match=0, Count=0, Err=0; internal history, bit index and seen-counter cleared. While Clr=0, Start is ignored.
- State encoding is IDLE, SCAN, DONE. Busy=(state==SCAN) and Done=(state==DONE) are decoded from state.
- IDLE, Start=1 at edge E0:
  - Capture Data, Pat and PatLen. Clear Count, Match and history; set seen=0 and idx=DW-1.
  - If PatLen==0 or PatLen>PMAX: Err<=1, go to DONE; no bits are scanned.
  - Otherwise: Err<=0, go to SCAN.
- IDLE, Start=0: remain in IDLE; Count and Err hold.
- SCAN, edge Ek (k=1..DW): consume bit b=Data_reg[DW-k].
  - hist_next={hist[PMAX-2:0], b}.
  - seen_next=min(seen+1, PMAX).
  - hit=(seen_next>=PatLen_reg) && (hist_next[PatLen-1:0]==Pat_reg[PatLen-1:0]).
  - Match<=hit.
  - Count<=Count+hit, saturating at 2^CW-1 (no wrap).
  - Matches overlap: the history is never cleared on a hit.
- SCAN exit: at edge E_DW the final bit is consumed, state goes to DONE, and the last Match is registered normally.
- DONE, next edge: state goes to IDLE and Match<=0. Done is therefore high for exactly the one cycle between E_DW and E_DW+1.
- Latency: Start accepted at E0, Busy high for cycles E0..E_DW, Done high one cycle. A legal command occupies the block for DW+2 edges; Start held high continuously is re-accepted at the first edge spent in IDLE.
- Start in SCAN or DONE: ignored and not queued.
- Data, Pat and PatLen changing after E0: no effect on the scan in progress.
- Reset mid-scan: immediate return to the reset values above; the scan is abandoned, no Done pulse, Count=0.

Test Plan:
- Basic overlapping scan: Pat=8'b00000101, PatLen=3, Data=16'hA5A5, pulse Start -> Busy high 16 cycles; Match pulses at E3, E8, E11, E16; Done one cycle after E16; Count=4, Err=0.
- Saturation: Pat=1, PatLen=1, Data=16'hFFFF -> Match high on E1..E16; Count stops at 15 (4'hF) and does not wrap to 0.
- Illegal length: PatLen=0, then PatLen=9, each with Start -> Busy never high, Done one cycle after E0, Err=1, Count=0, no Match. A following legal command clears Err to 0.
- Full-length pattern: PatLen=8, Pat=8'hA5, Data=16'h00A5 -> exactly one Match at E16, Count=1. Same pattern with Data=16'hA500 -> one Match at E8.
- Reset mid-scan: drive Clr=0 asynchronously at ~E5 of a scan -> Busy, Match and Count go to 0 without waiting for a clock edge; no Done. After release, a new Start runs a full scan correctly.
- Command robustness: hold Start=1 continuously and change Data during the scan -> the second Start is accepted at the first edge in IDLE (period DW+2 edges); in-flight results reflect only the captured Data.
